// File: rtl/led_pattern_if.sv
// Switch-side controls and LED-side outputs of the LED pattern engine.
// master drives the switches and observes the LEDs; slave is the engine itself.
interface led_pattern_if #(
  parameter int N_LEDS = 4
);
  logic              i_enable;
  logic [1:0]        i_speed;
  logic [1:0]        i_mode;
  logic [1:0]        i_color;
  logic [N_LEDS-1:0] o_led;
  logic [N_LEDS-1:0] o_led_r;
  logic [N_LEDS-1:0] o_led_g;
  logic [N_LEDS-1:0] o_led_b;
  logic              o_tick;

  modport master (
    output i_enable, i_speed, i_mode, i_color,
    input  o_led, o_led_r, o_led_g, o_led_b, o_tick
  );

  modport slave (
    input  i_enable, i_speed, i_mode, i_color,
    output o_led, o_led_r, o_led_g, o_led_b, o_tick
  );
endinterface

// File: rtl/led_pattern_gen.sv
// Prescaled LED pattern engine (rotate-left/right, bounce, binary count) steered to R/G/B banks.
// Define LEDPAT_BOUNCE_EN for bounce mode; without it mode 10 runs as rotate-left.
module led_pattern_gen #(
  parameter int                    N_LEDS     = 4,
  parameter int                    NB_COUNTER = 32,
  parameter logic [NB_COUNTER-1:0] R0         = NB_COUNTER'(2**23-1),
  parameter logic [NB_COUNTER-1:0] R1         = NB_COUNTER'(2**24-1),
  parameter logic [NB_COUNTER-1:0] R2         = NB_COUNTER'(2**25-1),
  parameter logic [NB_COUNTER-1:0] R3         = NB_COUNTER'(2**26-1)
) (
  input  logic         i_clock,
  input  logic         i_reset,
  led_pattern_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_ROL    = 2'b00,
    MODE_ROR    = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_CNT    = 2'b11
  } mode_t;

  logic [NB_COUNTER-1:0] r_count;
  logic [N_LEDS-1:0]     r_pattern;
  mode_t                 r_mode;
  logic                  r_tick;

  logic [NB_COUNTER-1:0] w_limit;
  logic [N_LEDS-1:0]     w_next;
  logic                  w_step;
  logic                  w_mode_chg;

`ifdef LEDPAT_BOUNCE_EN
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
  logic r_dir;
  logic w_dir_next;
`endif

  always_comb begin
    w_limit = R0;
    case (bus.i_speed)
      2'd1:    w_limit = R1;
      2'd2:    w_limit = R2;
      2'd3:    w_limit = R3;
      default: w_limit = R0;
    endcase
  end

  // >= rather than == so dropping to a faster speed mid-count steps at once instead of wrapping
  assign w_step     = (r_count >= w_limit);
  assign w_mode_chg = (mode_t'(bus.i_mode) != r_mode);

  always_comb begin
    w_next = r_pattern;
`ifdef LEDPAT_BOUNCE_EN
    w_dir_next = r_dir;
`endif
    case (r_mode)
      MODE_ROR: w_next = {r_pattern[0], r_pattern[N_LEDS-1:1]};
      MODE_CNT: w_next = r_pattern + N_LEDS'(1);
`ifdef LEDPAT_BOUNCE_EN
      MODE_BOUNCE: begin
        // direction flips on the edge step itself, so the end LEDs are lit for one period only
        if (r_dir == DIR_LEFT) begin
          if (r_pattern[N_LEDS-1]) begin
            w_dir_next = DIR_RIGHT;
            w_next     = r_pattern >> 1;
          end else begin
            w_next = r_pattern << 1;
          end
        end else begin
          if (r_pattern[0]) begin
            w_dir_next = DIR_LEFT;
            w_next     = r_pattern << 1;
          end else begin
            w_next = r_pattern >> 1;
          end
        end
      end
`endif
      default:  w_next = {r_pattern[N_LEDS-2:0], r_pattern[N_LEDS-1]};
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_count   <= '0;
      r_pattern <= N_LEDS'(1);
      r_mode    <= MODE_ROL;
      r_tick    <= 1'b0;
`ifdef LEDPAT_BOUNCE_EN
      r_dir     <= DIR_LEFT;
`endif
    end else if (!bus.i_enable) begin
      r_tick <= 1'b0;
    end else if (w_mode_chg) begin
      r_mode    <= mode_t'(bus.i_mode);
      r_pattern <= N_LEDS'(1);
      r_count   <= '0;
      r_tick    <= 1'b0;
`ifdef LEDPAT_BOUNCE_EN
      r_dir     <= DIR_LEFT;
`endif
    end else if (w_step) begin
      r_count   <= '0;
      r_pattern <= w_next;
      r_tick    <= 1'b1;
`ifdef LEDPAT_BOUNCE_EN
      r_dir     <= w_dir_next;
`endif
    end else begin
      r_count <= r_count + NB_COUNTER'(1);
      r_tick  <= 1'b0;
    end
  end

  assign bus.o_led   = r_pattern;
  assign bus.o_tick  = r_tick;
  assign bus.o_led_r = (bus.i_color == 2'b00 || bus.i_color == 2'b11) ? r_pattern : '0;
  assign bus.o_led_g = (bus.i_color == 2'b01 || bus.i_color == 2'b11) ? r_pattern : '0;
  assign bus.o_led_b = (bus.i_color == 2'b10 || bus.i_color == 2'b11) ? r_pattern : '0;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen: vector table plus hand sequences for speed change,
// freeze/resume, mode-change priority, mid-period reset and colour steering.
module tb_led_pattern_gen;

  typedef struct {
    logic       en;
    logic [1:0] speed;
    logic [1:0] mode;
    logic [1:0] color;
    int         n_clk;
    logic [3:0] led;
    logic       tick;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  vec_t vecs[$];
  logic [3:0] bseq [7];

  always #5 clk = ~clk;

  led_pattern_if #(.N_LEDS(4)) bus();

  led_pattern_gen #(
    .N_LEDS(4), .NB_COUNTER(32),
    .R0(32'd3), .R1(32'd7), .R2(32'd15), .R3(32'd31)
  ) dut (
    .i_clock(clk),
    .i_reset(rst),
    .bus(bus)
  );

  function automatic vec_t mk(input logic en, input logic [1:0] sp, input logic [1:0] md,
                              input logic [1:0] col, input int n, input logic [3:0] led,
                              input logic tick);
    vec_t v;
    v.en = en; v.speed = sp; v.mode = md; v.color = col;
    v.n_clk = n; v.led = led; v.tick = tick;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [3:0] led, input logic tick,
                           input logic [1:0] col);
    cmp({name, ".led"},  32'(bus.o_led),  32'(led));
    cmp({name, ".tick"}, 32'(bus.o_tick), 32'(tick));
    cmp({name, ".r"}, 32'(bus.o_led_r), (col == 2'd0 || col == 2'd3) ? 32'(led) : 32'd0);
    cmp({name, ".g"}, 32'(bus.o_led_g), (col == 2'd1 || col == 2'd3) ? 32'(led) : 32'd0);
    cmp({name, ".b"}, 32'(bus.o_led_b), (col == 2'd2 || col == 2'd3) ? 32'(led) : 32'd0);
  endtask

  task automatic step_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int tick_cnt;
    int led_chg;

`ifdef LEDPAT_BOUNCE_EN
    bseq = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
`else
    bseq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
`endif

    // rotate-left, speed 0: period 4
    vecs.push_back(mk(1, 0, 0, 0, 0, 4'b0001, 0));
    vecs.push_back(mk(1, 0, 0, 1, 3, 4'b0001, 0));
    vecs.push_back(mk(1, 0, 0, 2, 1, 4'b0010, 1));
    vecs.push_back(mk(1, 0, 0, 3, 1, 4'b0010, 0));
    vecs.push_back(mk(1, 0, 0, 0, 3, 4'b0100, 1));
    vecs.push_back(mk(1, 0, 0, 1, 4, 4'b1000, 1));
    vecs.push_back(mk(1, 0, 0, 2, 4, 4'b0001, 1));
    // rotate-right after a mode change
    vecs.push_back(mk(1, 0, 1, 3, 1, 4'b0001, 0));
    vecs.push_back(mk(1, 0, 1, 0, 4, 4'b1000, 1));
    vecs.push_back(mk(1, 0, 1, 1, 4, 4'b0100, 1));
    vecs.push_back(mk(1, 0, 1, 2, 4, 4'b0010, 1));
    vecs.push_back(mk(1, 0, 1, 3, 4, 4'b0001, 1));
    // bounce (or rotate-left fallback), speed 1: period 8
    vecs.push_back(mk(1, 1, 2, 0, 1, 4'b0001, 0));
    for (int k = 0; k < 7; k++)
      vecs.push_back(mk(1, 1, 2, 2'(k % 4), 8, bseq[k], 1));
    // binary count, speed 1, including the all-ones wrap
    vecs.push_back(mk(1, 1, 3, 1, 1, 4'b0001, 0));
    vecs.push_back(mk(1, 1, 3, 2, 7, 4'b0001, 0));
    vecs.push_back(mk(1, 1, 3, 3, 1, 4'b0010, 1));
    vecs.push_back(mk(1, 1, 3, 0, 8, 4'b0011, 1));
    vecs.push_back(mk(1, 1, 3, 1, 96, 4'b1111, 1));
    vecs.push_back(mk(1, 1, 3, 2, 8, 4'b0000, 1));
    vecs.push_back(mk(1, 1, 3, 3, 8, 4'b0001, 1));

    rst = 1'b1;
    bus.i_enable = 1'b1;
    bus.i_speed  = 2'd0;
    bus.i_mode   = 2'd0;
    bus.i_color  = 2'd0;
    step_clk(3);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      bus.i_enable = vecs[i].en;
      bus.i_speed  = vecs[i].speed;
      bus.i_mode   = vecs[i].mode;
      bus.i_color  = vecs[i].color;
      if (vecs[i].n_clk == 0) #1;
      else step_clk(vecs[i].n_clk);
      check_all($sformatf("v%0d", i), vecs[i].led, vecs[i].tick, vecs[i].color);
    end

    // slow speed part-way through, then drop to speed 0: step on the very next clock
    bus.i_color = 2'd3;
    bus.i_speed = 2'd3;
    tick_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      step_clk(1);
      tick_cnt += int'(bus.o_tick);
    end
    cmp("spd.no_tick_20", 32'(tick_cnt), 32'd0);
    check_all("spd.held", 4'b0001, 0, 2'd3);
    bus.i_speed = 2'd0;
    step_clk(1);
    check_all("spd.fast_step", 4'b0010, 1, 2'd3);
    step_clk(3);
    check_all("spd.gap", 4'b0010, 0, 2'd3);
    step_clk(1);
    check_all("spd.period4", 4'b0011, 1, 2'd3);

    // freeze at count 2 for 100 clocks, resume continues from held count
    step_clk(2);
    check_all("frz.pre", 4'b0011, 0, 2'd3);
    bus.i_enable = 1'b0;
    tick_cnt = 0;
    led_chg  = 0;
    for (int k = 0; k < 100; k++) begin
      step_clk(1);
      tick_cnt += int'(bus.o_tick);
      if (bus.o_led !== 4'b0011) led_chg++;
    end
    cmp("frz.no_tick", 32'(tick_cnt), 32'd0);
    cmp("frz.led_held", 32'(led_chg), 32'd0);
    bus.i_enable = 1'b1;
    step_clk(1);
    check_all("frz.resume1", 4'b0011, 0, 2'd3);
    step_clk(1);
    check_all("frz.resume2", 4'b0100, 1, 2'd3);
    for (int c = 0; c < 4; c++) begin
      bus.i_color = 2'(c);
      #1;
      check_all($sformatf("col%0d", c), 4'b0100, 1, 2'(c));
    end

    // mode change coinciding with a due step: change wins
    bus.i_color = 2'd3;
    step_clk(3);
    check_all("pri.pre", 4'b0100, 0, 2'd3);
    bus.i_mode = 2'd0;
    step_clk(1);
    check_all("pri.chg", 4'b0001, 0, 2'd3);
    step_clk(3);
    check_all("pri.gap", 4'b0001, 0, 2'd3);
    step_clk(1);
    check_all("pri.step", 4'b0010, 1, 2'd3);

    // reset when a step is due
    step_clk(3);
    check_all("rst.pre", 4'b0010, 0, 2'd3);
    rst = 1'b1;
    step_clk(1);
    check_all("rst.hit", 4'b0001, 0, 2'd3);
    rst = 1'b0;
    step_clk(3);
    check_all("rst.gap", 4'b0001, 0, 2'd3);
    step_clk(1);
    check_all("rst.step", 4'b0010, 1, 2'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
